song_queue_ctrl: RTL
====================

# song_queue_ctrl

Playlist scheduler between the launchpad input decoder and the song player. Queues song-number requests in a small FIFO, then sequences the player: loads each song with a one-cycle `reset_player` pulse, holds `play` while it runs, and advances on `song_done` or a user skip. Pause/resume and queue status are provided for the display logic.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, minimum 2
- `SONG_W`, 4, song-number width (16 songs)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  one-cycle strobe: enqueue `req_song`
- `req_song`  in  SONG_W  requested song number
- `pause_toggle`  in  1  one-cycle strobe: PLAY↔PAUSE
- `skip`  in  1  one-cycle strobe: abandon current song
- `song_done`  in  1  one-cycle strobe from the player at end of song
- `play`  out  1  player run enable
- `reset_player`  out  1  one-cycle player/note-reader reset
- `song`  out  SONG_W  song number presented to the player
- `queue_count`  out  $clog2(DEPTH)+1  occupied entries
- `queue_full`  out  1  `queue_count == DEPTH`
- `req_drop`  out  1  one-cycle pulse: a request was discarded

## Operation
- States: IDLE, LOAD, PLAY, PAUSE. `play` = (state == PLAY); `reset_player` = (state == LOAD) or end-pulse (below).
- IDLE: FIFO non-empty -> LOAD. On that transition `song` <= FIFO head; pop.
- LOAD: lasts exactly one cycle -> PLAY.
- PLAY: `skip` or `song_done` -> LOAD if FIFO non-empty (head loaded, popped), else IDLE with `reset_player` pulsed for that cycle; `song` holds its last value. Otherwise `pause_toggle` -> PAUSE.
- PAUSE: `skip` behaves as in PLAY. `song_done` is ignored. `pause_toggle` -> PLAY.
- Priority: `skip`/`song_done` over `pause_toggle`; the toggle is discarded.
- Enqueue: `req_valid` with count < DEPTH writes tail. A push and a pop in the same cycle are both honoured when full, leaving count unchanged. A push when full with no pop is discarded, and `req_drop` pulses on the next cycle.
- Pointers wrap modulo DEPTH. Count arithmetic is saturating-free; overflow is prevented by the rules above.
- `song_done`/`skip` in IDLE or LOAD are ignored.

## Timing
- Reset (async assert, sync deassert upstream): state IDLE, `play` 0, `reset_player` 0, `song` 0, `queue_count` 0, `queue_full` 0, `req_drop` 0, pointers 0.
- `req_valid` at cycle N into an empty idle queue:
  - `queue_count` = 1 at N+1
  - LOAD, `song` valid, and `reset_player` = 1 at N+2; `queue_count` back to 0 at N+2
  - `play` = 1 at N+3
- `song_done` at cycle M with the queue non-empty: LOAD at M+1, PLAY at M+2. `play` is low for exactly one cycle.
- `pause_toggle` at M: `play` changes at M+1.
- All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.

## Configuration
- `SONG_QUEUE_REPEAT_EN` defined: a song ending by `song_done` (not `skip`) is re-pushed to the tail in the cycle after the end event. The re-push takes priority over `req_valid` in that cycle; the competing request is dropped with `req_drop`. The playlist loops indefinitely.
- Undefined: finished songs are discarded, and the block returns to IDLE when the queue empties.

## Structure
- Shared package `song_pkg`:
  - `SONG_W`
  - state enum/localparams `ST_IDLE`=0, `ST_LOAD`=1, `ST_PLAY`=2, `ST_PAUSE`=3
- Sub-module `song_fifo`: synchronous FIFO with push, pop, head, count, and full/empty outputs, parameterised by DEPTH/SONG_W, built on the team's `dffr` registers.
- The FSM and drop logic live in `song_queue_ctrl`.

## Test plan
- Reset mid-PLAY with 3 queued -> all outputs 0 and `queue_count` 0 immediately; after release with no requests, remains IDLE.
- Enqueue 5, then 9 -> `song`=5 with `reset_player` at N+2, `play` at N+3; `song_done` -> `song`=9 with one-cycle `play` gap; second `song_done` -> IDLE, `reset_player` pulse, `play` 0.
- Enqueue 8 songs while paused -> `queue_full`=1; a 9th request -> `req_drop` pulse and `queue_count` stays 8; `skip` plus a request in the same cycle -> both accepted, count 8.
- PLAY, `pause_toggle` -> `play` 0; `song_done` while paused ignored; `skip` while paused with queue empty -> IDLE.
- `skip` and `pause_toggle` in the same cycle with 1 queued -> LOAD; no PAUSE entered.
- With `SONG_QUEUE_REPEAT_EN`: queue {2,7}, two `song_done` events -> order 2,7,2,7; `skip` on 7 removes it from the loop.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the playlist scheduler: song-number width and FSM state encoding.
package song_pkg;

  localparam int SONG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/dffr.sv
// Enabled D register with asynchronous active-low reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/song_fifo.sv
// Song-number FIFO built from dffr registers; the caller guarantees no push when full
// without a same-cycle pop, and no pop when empty.
module song_fifo #(
  parameter int DEPTH  = 8,
  parameter int SONG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [SONG_W-1:0]        wdata,
  output logic [SONG_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_d;
  logic [SONG_W-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    dffr #(.W(SONG_W)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (push && (wr_ptr == PW'(i))),
      .d     (wdata),
      .q     (mem[i])
    );
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  dffr #(.W(PW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .en(push), .d(wr_ptr + PW'(1)), .q(wr_ptr)
  );

  dffr #(.W(PW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .en(pop), .d(rd_ptr + PW'(1)), .q(rd_ptr)
  );

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CW'(1);
    else if (pop && !push) count_d = count - CW'(1);
  end

  dffr #(.W(CW)) u_count (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(count_d), .q(count)
  );

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/song_queue_ctrl.sv
// Playlist scheduler: queues song requests and sequences the player (IDLE/LOAD/PLAY/PAUSE).
// Define SONG_QUEUE_REPEAT_EN to loop the playlist by re-pushing songs that finish normally.
module song_queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int SONG_W = song_pkg::SONG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [SONG_W-1:0]      req_song,
  input  logic                   pause_toggle,
  input  logic                   skip,
  input  logic                   song_done,
  output logic                   play,
  output logic                   reset_player,
  output logic [SONG_W-1:0]      song,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   queue_full,
  output logic                   req_drop,
  output song_pkg::state_t       state_dbg
);

  import song_pkg::*;

  // All control inputs are single-cycle strobes with no ready/backpressure: a request that
  // cannot be stored is discarded and reported one cycle later on req_drop.
  state_t            state;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SONG_W-1:0] fifo_head;
  logic [SONG_W-1:0] push_data;
  logic              push_req;
  logic              end_evt;
  logic              space;
  logic              drop_d;

  assign end_evt  = ((state == ST_PLAY) && (skip || song_done)) ||
                    ((state == ST_PAUSE) && skip);
  assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || end_evt);
  assign space    = !fifo_full || fifo_pop;

`ifdef SONG_QUEUE_REPEAT_EN
  logic              repush_pend;
  logic [SONG_W-1:0] repush_song;

  // The ended song is captured here because song may already hold the next head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      repush_pend <= 1'b0;
      repush_song <= '0;
    end else begin
      repush_pend <= (state == ST_PLAY) && song_done && !skip;
      repush_song <= song;
    end
  end

  assign push_req  = repush_pend || req_valid;
  assign push_data = repush_pend ? repush_song : req_song;
  assign drop_d    = req_valid && (repush_pend || !space);
`else
  assign push_req  = req_valid;
  assign push_data = req_song;
  assign drop_d    = req_valid && !space;
`endif

  assign fifo_push = push_req && space;

  song_fifo #(.DEPTH(DEPTH), .SONG_W(SONG_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_data),
    .head  (fifo_head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      play         <= 1'b0;
      reset_player <= 1'b0;
      song         <= '0;
      req_drop     <= 1'b0;
    end else begin
      req_drop     <= drop_d;
      reset_player <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state        <= ST_LOAD;
            song         <= fifo_head;
            reset_player <= 1'b1;
          end
        end
        ST_LOAD: begin
          state <= ST_PLAY;
          play  <= 1'b1;
        end
        ST_PLAY, ST_PAUSE: begin
          if (end_evt) begin
            // Ending with an empty queue still pulses reset_player to park the player.
            reset_player <= 1'b1;
            play         <= 1'b0;
            if (!fifo_empty) begin
              state <= ST_LOAD;
              song  <= fifo_head;
            end else begin
              state <= ST_IDLE;
            end
          end else if (pause_toggle) begin
            state <= (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
            play  <= (state == ST_PAUSE);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign queue_full = fifo_full;
  assign state_dbg  = state;

endmodule
